// File: rtl/alu_mul_seq_if.sv
// Bus between the shift-add multiply sequencer, its requester and the shared ALU.
// The slave side is the sequencer; the master side is the requester plus the ALU.
interface alu_mul_seq_if;
  logic        start;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic        busy;
  logic        done;
  logic [31:0] prod_hi;
  logic [31:0] prod_lo;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_res;

  modport master (
    output start, mcand, mplier, alu_res,
    input  busy, done, prod_hi, prod_lo, alu_a, alu_b, alu_op
  );

  modport slave (
    input  start, mcand, mplier, alu_res,
    output busy, done, prod_hi, prod_lo, alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/alu_mul_seq.sv
// 32x32 unsigned shift-add multiplier that borrows the datapath's combinational ALU
// for every partial-sum addition; one iteration per cycle, 32 iterations per product.
module alu_mul_seq #(
  parameter logic [2:0] OP_ADD = 3'b000,
  parameter int         CNT_W  = 5
) (
  input  logic         clk,
  input  logic         rst,
  alu_mul_seq_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      mcand_q, mcand_d;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic             carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
    end
  end

  // Carry-out of the 32-bit add, rebuilt from operand and result MSBs.
  assign carry = (alu_a[31] & alu_b[31]) | ((alu_a[31] | alu_b[31]) & ~bus.alu_res[31]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          mcand_d = bus.mcand;
          hi_d    = '0;
          lo_d    = bus.mplier;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // {carry, sum, lo} shifted right by one: multiplier bits retire out of lo.
        hi_d  = {carry, bus.alu_res[31:1]};
        lo_d  = {bus.alu_res[0], lo_q[31:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    if (state_q == S_RUN) begin
      alu_a = hi_q;
      alu_b = lo_q[0] ? mcand_q : '0;
    end
  end

  assign bus.alu_a   = alu_a;
  assign bus.alu_b   = alu_b;
  assign bus.alu_op  = OP_ADD;
  assign bus.busy    = (state_q == S_RUN);
  assign bus.done    = (state_q == S_DONE);
  assign bus.prod_hi = hi_q;
  assign bus.prod_lo = lo_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq: stimulus queues hand-computed products, a monitor
// pops one per done pulse and also watches busy length and the ALU drive.
module tb_alu_mul_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cycle = 0;
  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_val;
  int          busy_run = 0;
  logic        prev_busy = 1'b0;
  int          t1, t2;

  alu_mul_seq_if bus ();

  // Combinational ALU model: only addition is ever requested.
  assign bus.alu_res = bus.alu_a + bus.alu_b;

  alu_mul_seq #(.OP_ADD(3'b000), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%h", name, act);
    end
  endtask

  // Monitor: decoupled from stimulus, compares on every done pulse.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      busy_run  = 0;
      prev_busy = 1'b0;
    end else begin
      checks++;
      if (bus.alu_op !== 3'b000) begin
        errors++;
        $display("FAIL alu_op: got %b expected 000 at cycle %0d", bus.alu_op, cycle);
      end
      if (bus.busy) begin
        busy_run++;
      end else begin
        checks++;
        if (bus.alu_a !== 32'h0 || bus.alu_b !== 32'h0) begin
          errors++;
          $display("FAIL alu_idle: got a=0x%h b=0x%h expected 0 at cycle %0d",
                   bus.alu_a, bus.alu_b, cycle);
        end
      end
      if (bus.done) begin
        check("done_follows_busy", {62'd0, bus.busy, prev_busy}, 64'd1);
        check("busy_cycles", 64'(busy_run), 64'd32);
        busy_run = 0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got prod 0x%h_%h expected no done",
                   bus.prod_hi, bus.prod_lo);
        end else begin
          exp_val = exp_q.pop_front();
          check("product", {bus.prod_hi, bus.prod_lo}, exp_val);
        end
      end
      prev_busy = bus.busy;
    end
  end

  task automatic launch(input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input bit push);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mcand  = a;
    bus.mplier = b;
    if (push) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("busy_after_accept", {63'd0, bus.busy}, 64'd1);
  endtask

  task automatic wait_done(input string tag, output int at);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: got done=0 expected done=1", tag);
    end
    at = cycle;
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.mcand  = 32'h0;
    bus.mplier = 32'h0;

    #2;
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_prod", {bus.prod_hi, bus.prod_lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    launch(32'd3, 32'd4, 64'h0000_0000_0000_000C, 1'b1);
    wait_done("basic", t1);

    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
    wait_done("carry", t1);

    launch(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, 1'b1);
    wait_done("highbit", t1);
    launch(32'h1234_5678, 32'd0, 64'h0, 1'b1);
    wait_done("zero", t1);

    // start during RUN cycle 10 must be ignored
    launch(32'd5, 32'd7, 64'h0000_0000_0000_0023, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    bus.start  = 1'b1;
    bus.mcand  = 32'd9;
    bus.mplier = 32'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("ignored_start", t1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_after_ignored", {62'd0, bus.busy, bus.done}, 64'd0);
    end

    // asynchronous reset mid-operation: no product expected
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0, 1'b0);
    repeat (14) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", {63'd0, bus.busy}, 64'd0);
    check("midrst_done", {63'd0, bus.done}, 64'd0);
    check("midrst_prod", {bus.prod_hi, bus.prod_lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    launch(32'd3, 32'd4, 64'h0000_0000_0000_000C, 1'b1);
    wait_done("after_reset", t1);

    // back-to-back with start held high
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mcand  = 32'd6;
    bus.mplier = 32'd7;
    exp_q.push_back(64'h0000_0000_0000_002A);
    exp_q.push_back(64'h0000_0001_0000_0000);
    @(posedge clk);
    wait_done("b2b_first", t1);
    bus.mcand  = 32'h0001_0000;
    bus.mplier = 32'h0001_0000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("b2b_second", t2);
    check("b2b_gap", 64'(t2 - t1), 64'd33);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
